// File: rtl/imem_ctrl.sv
// Instruction-memory port arbiter: the boot loader streams words into memory,
// then the fetch path drives the PC through the run and halt phases.
module imem_ctrl #(
  parameter int                  tamanho       = 32,
  parameter int                  enderecamento = 10,
  parameter logic [tamanho-1:0]  RESET_PC      = '0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     load_start,
  input  logic                     run_start,
  input  logic                     load_valid,
  input  logic [tamanho-1:0]       load_data,
  input  logic                     load_last,
  output logic                     load_ready,
  input  logic [tamanho-1:0]       pc_next,
  input  logic                     stall,
  input  logic                     halt_req,
  output logic [tamanho-1:0]       mem_addr,
  output logic [tamanho-1:0]       mem_wdata,
  output logic                     mem_we,
  output logic [tamanho-1:0]       pc,
  output logic                     instr_valid,
  output logic [1:0]               state,
  output logic [enderecamento:0]   load_count,
  output logic                     error
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10,
    HALT = 2'b11
  } state_t;

  localparam logic [enderecamento-1:0] WPTR_MAX  = '1;
  localparam logic [enderecamento-1:0] WPTR_ONE  = 1;
  localparam logic [enderecamento:0]   COUNT_ONE = 1;

  state_t                   state_reg;
  logic [tamanho-1:0]       pc_reg;
  logic [enderecamento-1:0] wptr_reg;
  logic [enderecamento:0]   load_count_reg;
  logic                     error_reg;
  logic                     accept;
  logic [tamanho-1:0]       load_addr;

  assign load_ready  = (state_reg == LOAD);
  assign accept      = load_valid & load_ready;
  assign mem_we      = accept;
  assign mem_wdata   = load_data;
  assign instr_valid = (state_reg == RUN);
  assign pc          = pc_reg;
  assign state       = state_reg;
  assign load_count  = load_count_reg;
  assign error       = error_reg;

  // Loader writes go to the word pointer; every other phase presents the PC.
  always_comb begin
    load_addr = '0;
    load_addr[enderecamento+1:0] = {wptr_reg, 2'b00};
  end

  assign mem_addr = (state_reg == LOAD) ? load_addr : pc_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      pc_reg         <= RESET_PC;
      wptr_reg       <= '0;
      load_count_reg <= '0;
      error_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, HALT: begin
          if (load_start) begin
            state_reg      <= LOAD;
            wptr_reg       <= '0;
            load_count_reg <= '0;
            error_reg      <= 1'b0;
          end else if (run_start) begin
            state_reg <= RUN;
          end
        end
        LOAD: begin
          if (accept) begin
            wptr_reg       <= wptr_reg + WPTR_ONE;
            load_count_reg <= load_count_reg + COUNT_ONE;
            if (load_last) begin
              state_reg <= RUN;
              pc_reg    <= RESET_PC;
            end else if (wptr_reg == WPTR_MAX) begin
              // Last slot filled without the final word: the image does not fit.
              error_reg <= 1'b1;
              state_reg <= IDLE;
            end
          end
        end
        RUN: begin
          if (halt_req) begin
            state_reg <= HALT;
          end else if (!stall) begin
            if (pc_next[1:0] != 2'b00) begin
              error_reg <= 1'b1;
              state_reg <= HALT;
            end else begin
              pc_reg <= pc_next;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_ctrl.sv
// Directed bench for imem_ctrl: a full-size instance with a behavioural memory
// for load/run/halt, and a 4-word instance for the image-overflow case.
module tb_imem_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        load_start, run_start, load_valid, load_last;
  logic [31:0] load_data, pc_next;
  logic        stall, halt_req;
  logic        load_ready, mem_we, instr_valid, error;
  logic [31:0] mem_addr, mem_wdata, pc;
  logic [1:0]  state;
  logic [10:0] load_count;

  logic        b_reset, b_load_start, b_load_valid, b_load_last;
  logic [31:0] b_load_data;
  logic        b_load_ready, b_mem_we, b_instr_valid, b_error;
  logic [31:0] b_mem_addr, b_mem_wdata, b_pc;
  logic [1:0]  b_state;
  logic [2:0]  b_load_count;

  logic [31:0] imem [0:1023];
  logic [31:0] instr;
  logic [31:0] words [0:3];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  always @(posedge clock) if (mem_we) imem[mem_addr[11:2]] <= mem_wdata;
  assign instr = imem[mem_addr[11:2]];

  imem_ctrl dut (
    .clock(clock), .reset(reset), .load_start(load_start), .run_start(run_start),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .pc_next(pc_next), .stall(stall), .halt_req(halt_req),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .pc(pc),
    .instr_valid(instr_valid), .state(state), .load_count(load_count), .error(error)
  );

  imem_ctrl #(.enderecamento(2)) dut_small (
    .clock(clock), .reset(b_reset), .load_start(b_load_start), .run_start(1'b0),
    .load_valid(b_load_valid), .load_data(b_load_data), .load_last(b_load_last),
    .load_ready(b_load_ready), .pc_next(32'h0), .stall(1'b0), .halt_req(1'b0),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we), .pc(b_pc),
    .instr_valid(b_instr_valid), .state(b_state), .load_count(b_load_count), .error(b_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    words[0] = 32'h20080005; words[1] = 32'h20090003;
    words[2] = 32'h01095020; words[3] = 32'hAC0A0000;
    reset = 1'b1; load_start = 0; run_start = 0; load_valid = 0; load_last = 0;
    load_data = 0; pc_next = 0; stall = 0; halt_req = 0;
    b_reset = 1'b1; b_load_start = 0; b_load_valid = 0; b_load_last = 0; b_load_data = 0;

    tick();
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_count", 32'(load_count), 32'h0);
    chk("rst_error", 32'(error), 32'h0);
    chk("rst_ready", 32'(load_ready), 32'h0);
    chk("rst_we", 32'(mem_we), 32'h0);
    chk("rst_ivalid", 32'(instr_valid), 32'h0);
    reset = 1'b0;
    tick();

    // load_start beats a simultaneous run_start
    load_start = 1; run_start = 1;
    tick();
    load_start = 0; run_start = 0;
    chk("enter_load", 32'(state), 32'h1);
    chk("load_ready", 32'(load_ready), 32'h1);

    for (int i = 0; i < 4; i++) begin
      load_valid = 1; load_data = words[i]; load_last = (i == 3);
      run_start = (i == 1); halt_req = (i == 1);
      #1;
      chk("load_we", 32'(mem_we), 32'h1);
      chk("load_addr", mem_addr, 32'(i * 4));
      chk("load_wdata", mem_wdata, words[i]);
      $display("load word %0d addr %h data %h", i, mem_addr, mem_wdata);
      tick();
      run_start = 0; halt_req = 0;
      if (i < 3) chk("still_load", 32'(state), 32'h1);
    end
    load_valid = 0; load_last = 0;
    chk("run_state", 32'(state), 32'h2);
    chk("run_pc0", pc, 32'h0);
    chk("run_count", 32'(load_count), 32'h4);
    chk("run_error", 32'(error), 32'h0);
    chk("run_ivalid", 32'(instr_valid), 32'h1);
    chk("fetch0", instr, words[0]);

    pc_next = 32'h4; tick();
    chk("pc_1", pc, 32'h4);
    chk("fetch1", instr, words[1]);
    stall = 1; pc_next = 32'h8; tick();
    chk("pc_stall", pc, 32'h4);
    chk("ivalid_stall", 32'(instr_valid), 32'h1);
    stall = 0; tick();
    chk("pc_3", pc, 32'h8);
    chk("fetch2", instr, words[2]);

    halt_req = 1; stall = 1; pc_next = 32'hC; tick();
    halt_req = 0; stall = 0;
    chk("halt_state", 32'(state), 32'h3);
    chk("halt_pc", pc, 32'h8);
    chk("halt_ivalid", 32'(instr_valid), 32'h0);
    chk("halt_addr", mem_addr, 32'h8);
    run_start = 1; tick();
    run_start = 0;
    chk("resume_state", 32'(state), 32'h2);
    chk("resume_pc", pc, 32'h8);

    pc_next = 32'h6; tick();
    chk("mis_error", 32'(error), 32'h1);
    chk("mis_state", 32'(state), 32'h3);
    chk("mis_pc", pc, 32'h8);

    // reload from HALT clears error, then reset strikes mid-load
    load_start = 1; tick();
    load_start = 0;
    chk("reload_state", 32'(state), 32'h1);
    chk("reload_error", 32'(error), 32'h0);
    chk("reload_count", 32'(load_count), 32'h0);
    for (int i = 0; i < 2; i++) begin
      load_valid = 1; load_data = words[i]; load_last = 0;
      #1;
      $display("reload word %0d addr %h data %h", i, mem_addr, mem_wdata);
      tick();
    end
    chk("reload_count2", 32'(load_count), 32'h2);
    #2 reset = 1;
    #1;
    chk("arst_state", 32'(state), 32'h0);
    chk("arst_count", 32'(load_count), 32'h0);
    chk("arst_ready", 32'(load_ready), 32'h0);
    chk("arst_pc", pc, 32'h0);
    load_valid = 0;
    tick();
    reset = 0;

    // 4-word memory: image of 5 words overflows after the 4th accept
    b_reset = 0;
    tick();
    b_load_start = 1; tick();
    b_load_start = 0;
    chk("b_load_state", 32'(b_state), 32'h1);
    for (int i = 0; i < 4; i++) begin
      b_load_valid = 1; b_load_data = 32'h100 + 32'(i); b_load_last = 0;
      #1;
      chk("b_we", 32'(b_mem_we), 32'h1);
      chk("b_addr", b_mem_addr, 32'(i * 4));
      $display("small load word %0d addr %h data %h", i, b_mem_addr, b_mem_wdata);
      tick();
    end
    chk("b_error", 32'(b_error), 32'h1);
    chk("b_state", 32'(b_state), 32'h0);
    chk("b_count", 32'(b_load_count), 32'h4);
    b_load_data = 32'h104;
    #1;
    chk("b_ready5", 32'(b_load_ready), 32'h0);
    chk("b_we5", 32'(b_mem_we), 32'h0);
    b_load_valid = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_ctrl.md
Name: imem_ctrl

Overview:
- Owns the instruction-memory address and write port.
- Shares that port between a boot loader, which streams program words into a writable instruction memory, and the processor fetch path, which drives the PC.
- Sequences the boot, run and halt phases. Sits between the loader interface, the PC datapath and the writable instruction memory, whose read is combinational and write is synchronous.

Parameters:
tamanho, 32, data/address width in bits
enderecamento, 10, word-address bits; memory depth = 2^enderecamento words
RESET_PC, 0, byte address loaded into pc on reset and after each load

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
load_start  input  1  pulse: begin a program load
run_start  input  1  pulse: start or resume execution
load_valid  input  1  loader word present on load_data
load_data  input  tamanho  program word
load_last  input  1  qualifies load_data as the final word
load_ready  output  1  controller accepts a loader word this cycle
pc_next  input  tamanho  next PC computed by the datapath
stall  input  1  hold pc this cycle
halt_req  input  1  stop fetching
mem_addr  output  tamanho  byte address to instruction memory
mem_wdata  output  tamanho  write data to instruction memory
mem_we  output  1  instruction-memory write enable
pc  output  tamanho  current PC
instr_valid  output  1  memory output is a valid fetched instruction
state  output  2  IDLE=00, LOAD=01, RUN=10, HALT=11
load_count  output  enderecamento+1  words written by the last or current load
error  output  1  sticky fault flag; cleared only by reset or load_start

Behaviour:
- Reset (asynchronous, any state, mid-load included):
  - state=IDLE, pc=RESET_PC, wptr=0, load_count=0, error=0.
  - load_ready=0, mem_we=0, instr_valid=0.
  - A partially loaded image is not invalidated; the memory is not cleared.
- IDLE:
  - load_start -> LOAD; wptr=0, load_count=0, error=0.
  - Else run_start -> RUN.
  - load_start wins over a simultaneous run_start.
- LOAD:
  - load_ready=1 (combinational on state).
  - Accept = load_valid & load_ready.
  - mem_we = accept, combinational; mem_addr={wptr,2'b00}; mem_wdata=load_data.
  - On accept: wptr and load_count increment next cycle.
  - Accept with load_last=1 -> RUN next cycle, pc=RESET_PC.
  - Accept while wptr = 2^enderecamento-1 and load_last=0:
    - The word is written.
    - error<=1; state -> IDLE (image overflow).
  - load_start, run_start and halt_req are ignored in LOAD.
- RUN:
  - mem_addr=pc; instr_valid=1; mem_we=0; load_ready=0.
  - Each clock: if halt_req -> HALT with pc held; elif stall, pc held; else pc<=pc_next. halt_req wins over stall.
  - pc_next[1:0]!=0 without stall or halt: pc not updated, error<=1, state -> HALT.
  - pc_next at or beyond the depth wraps naturally; the memory uses only bits [enderecamento+1:2]. No error is raised.
- HALT:
  - instr_valid=0; mem_addr=pc.
  - load_start -> LOAD, as from IDLE.
  - Else run_start -> RUN, resuming at the held pc.
- Latency:
  - Fetched instruction is available the same cycle pc is presented.
  - Loader words are written at the accepting clock edge; no buffering.
- IDLE outputs: mem_addr=pc; instr_valid=0; mem_we=0.

Test Plan:
- Reset then load_start, 4 words 0x20080005, 0x20090003, 0x01095020, 0xAC0A0000 (last on 4th) -> mem_we pulses at addresses 0x0, 0x4, 0x8, 0xC; load_count=4; state=RUN; pc=0x0; error=0.
- RUN with pc_next=pc+4 for 3 cycles, stall on cycle 2 -> pc sequence 0x0, 0x4, 0x4, 0x8; instr_valid=1 throughout.
- halt_req and stall together at pc=0x8 -> state=HALT, pc=0x8, instr_valid=0. Then run_start -> RUN, pc=0x8.
- pc_next=0x6 unstalled -> error=1, state=HALT, pc unchanged.
- enderecamento=2: load 5 words without load_last -> 4 writes occur; error=1 and state=IDLE after the 4th accept; 5th word never ready.
- reset asserted after 2 of 4 loader words -> immediately state=IDLE, load_count=0, load_ready=0, pc=RESET_PC.
